// File: rtl/gpo_pad_ctrl.sv
// Control stage for one 1.8 V GPO pad: registers all pad pins and sequences
// configuration changes (drain, apply, bias qualify, settle) so the pad never glitches.
module gpo_pad_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned VBIAS_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [1:0] cfg_mode_i,
    input  logic [3:0] cfg_ds_i,
    input  logic       cfg_sr_i,
    input  logic       cfg_co_i,
    input  logic       data_i,
    input  logic       vbias_ok_i,
    output logic       pad_do_o,
    output logic [3:0] pad_ds_o,
    output logic       pad_sr_o,
    output logic       pad_co_o,
    output logic       pad_oe_o,
    output logic       pad_odp_o,
    output logic       pad_odn_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        ST_ACTIVE    = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_APPLY     = 3'd2,
        ST_BIAS_WAIT = 3'd3,
        ST_SETTLE    = 3'd4
    } state_t;

    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] BW_LAST     = 16'(VBIAS_TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [15:0] bw_cnt_r;
    logic        vb_meta_r;
    logic        vb_sync_r;
    logic [1:0]  sh_mode_r;
    logic [3:0]  sh_ds_r;
    logic        sh_sr_r;
    logic        sh_co_r;
    logic        pad_do_r;
    logic [3:0]  pad_ds_r;
    logic        pad_sr_r;
    logic        pad_co_r;
    logic        pad_oe_r;
    logic        pad_odp_r;
    logic        pad_odn_r;
    logic        busy_r;
    logic        err_r;
    logic        ready_r;
    logic        oe_block_r;
    logic        bias_needed_s;

    assign bias_needed_s = (pad_ds_r[1:0] != 2'b00);

    // Two-flop synchroniser for the asynchronous VBIAS-valid level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vb_meta_r <= 1'b0;
            vb_sync_r <= 1'b0;
        end else begin
            vb_meta_r <= vbias_ok_i;
            vb_sync_r <= vb_meta_r;
        end
    end

    // Output data path, independent of the configuration sequence
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_do_r <= 1'b0;
        end else begin
            pad_do_r <= data_i;
        end
    end

    // Configuration sequencer with registered pad controls and status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_ACTIVE;
            cnt_r      <= 8'd0;
            bw_cnt_r   <= 16'd0;
            sh_mode_r  <= 2'b00;
            sh_ds_r    <= 4'd0;
            sh_sr_r    <= 1'b0;
            sh_co_r    <= 1'b0;
            pad_ds_r   <= 4'd0;
            pad_sr_r   <= 1'b0;
            pad_co_r   <= 1'b0;
            pad_oe_r   <= 1'b0;
            pad_odp_r  <= 1'b0;
            pad_odn_r  <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            ready_r    <= 1'b1;
            oe_block_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACTIVE: begin
                    if (cfg_valid_i && ready_r) begin
                        sh_mode_r  <= cfg_mode_i;
                        sh_ds_r    <= cfg_ds_i;
                        sh_sr_r    <= cfg_sr_i;
                        sh_co_r    <= cfg_co_i;
                        err_r      <= 1'b0;
                        oe_block_r <= 1'b0;
                        pad_oe_r   <= 1'b0;
                        cnt_r      <= SETTLE_LOAD;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_DRAIN;
                    end else if (pad_oe_r && bias_needed_s && !vb_sync_r) begin
                        // Bias lost under load: latch off until the next config
                        pad_oe_r   <= 1'b0;
                        err_r      <= 1'b1;
                        oe_block_r <= 1'b1;
                    end else begin
                        pad_oe_r   <= (sh_mode_r != 2'b00) && !oe_block_r;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_APPLY;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_APPLY: begin
                    pad_ds_r  <= sh_ds_r;
                    pad_sr_r  <= sh_sr_r;
                    pad_co_r  <= sh_co_r;
                    pad_odp_r <= (sh_mode_r == 2'b10);
                    pad_odn_r <= (sh_mode_r == 2'b11);
                    bw_cnt_r  <= 16'd0;
                    state_r   <= ST_BIAS_WAIT;
                end
                ST_BIAS_WAIT: begin
                    if (!bias_needed_s || vb_sync_r) begin
                        cnt_r   <= SETTLE_LOAD;
                        state_r <= ST_SETTLE;
                    end else if (bw_cnt_r == BW_LAST) begin
                        // Fallback: drop to the strengths that need no bias
                        err_r         <= 1'b1;
                        pad_ds_r[1:0] <= 2'b00;
                        cnt_r         <= SETTLE_LOAD;
                        state_r       <= ST_SETTLE;
                    end else begin
                        bw_cnt_r <= bw_cnt_r + 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == 8'd0) begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_ACTIVE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    pad_oe_r <= 1'b0;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_ACTIVE;
                end
            endcase
        end
    end

    assign cfg_ready_o = ready_r;
    assign pad_do_o    = pad_do_r;
    assign pad_ds_o    = pad_ds_r;
    assign pad_sr_o    = pad_sr_r;
    assign pad_co_o    = pad_co_r;
    assign pad_oe_o    = pad_oe_r;
    assign pad_odp_o   = pad_odp_r;
    assign pad_odn_o   = pad_odn_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Scoreboard bench for gpo_pad_ctrl: stimulus pushes expected end-of-sequence
// pad state and timing; a negedge monitor pops and compares when busy_o falls.
module tb_gpo_pad_ctrl;

    localparam int S  = 8;
    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_ds;
    logic       cfg_sr;
    logic       cfg_co;
    logic       data;
    logic       vbias_ok;
    logic       pad_do;
    logic [3:0] pad_ds;
    logic       pad_sr;
    logic       pad_co;
    logic       pad_oe;
    logic       pad_odp;
    logic       pad_odn;
    logic       busy;
    logic       err;

    gpo_pad_ctrl #(.SETTLE_CYCLES(S), .VBIAS_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_mode_i(cfg_mode), .cfg_ds_i(cfg_ds), .cfg_sr_i(cfg_sr), .cfg_co_i(cfg_co),
        .data_i(data), .vbias_ok_i(vbias_ok),
        .pad_do_o(pad_do), .pad_ds_o(pad_ds), .pad_sr_o(pad_sr), .pad_co_o(pad_co),
        .pad_oe_o(pad_oe), .pad_odp_o(pad_odp), .pad_odn_o(pad_odn),
        .busy_o(busy), .err_o(err)
    );

    typedef struct {
        int busy_lat;
        int oe;
        int err;
        int ds;
        int sr;
        int co;
        int odp;
        int odn;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   t0 = -1;
    int   xfer_cnt = 0;
    logic exp_do = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        exp_do <= rst_n ? data : 1'b0;
        if (rst_n && cfg_valid && cfg_ready) begin
            t0       <= edge_n + 1;
            xfer_cnt <= xfer_cnt + 1;
        end
    end

    // Monitor: data path every cycle, sequence results when busy_o falls
    initial begin
        bit   prev_busy = 1'b0;
        bit   pend = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                pend = 1'b0;
            end else begin
                chk("pad_do", int'(pad_do), int'(exp_do));
                if (pend) begin
                    chk("oe_after_seq", int'(pad_oe), cur.oe);
                    chk("err_after_seq", int'(err), cur.err);
                    pend = 1'b0;
                end
                if (edge_n == t0) begin
                    chk("oe_drain_start", int'(pad_oe), 0);
                    chk("err_clear_on_xfer", int'(err), 0);
                    chk("busy_on_xfer", int'(busy), 1);
                end
                if (prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_seq", 1, 0);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("busy_latency", edge_n - t0, cur.busy_lat);
                        chk("oe_low_at_busy_fall", int'(pad_oe), 0);
                        chk("ds", int'(pad_ds), cur.ds);
                        chk("sr", int'(pad_sr), cur.sr);
                        chk("co", int'(pad_co), cur.co);
                        chk("odp", int'(pad_odp), cur.odp);
                        chk("odn", int'(pad_odn), cur.odn);
                        chk("err_at_busy_fall", int'(err), cur.err);
                        pend = 1'b1;
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        data = 1'($urandom_range(0, 1));
    endtask

    // r: cycles after the transfer edge at which vbias_ok rises (-1: already high)
    task automatic send(input logic [1:0] m, input logic [3:0] d, input logic s,
                        input logic c, input int r, input bit hold);
        exp_t e;
        int   ex;
        int   n;
        ex = S + 2;
        if (d[1:0] != 2'b00 && r >= 0 && r + 3 > ex) ex = r + 3;
        e.err = 0;
        e.ds  = int'(d);
        if (ex > S + 1 + TO) begin
            ex    = S + 1 + TO;
            e.err = 1;
            e.ds  = int'(d) & 12;
        end
        e.busy_lat = ex + S;
        e.oe  = (m != 2'b00) ? 1 : 0;
        e.sr  = int'(s);
        e.co  = int'(c);
        e.odp = (m == 2'b10) ? 1 : 0;
        e.odn = (m == 2'b11) ? 1 : 0;
        cfg_mode  = m;
        cfg_ds    = d;
        cfg_sr    = s;
        cfg_co    = c;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            chk("ready_timeout", 0, 1);
            cfg_valid = 1'b0;
        end else begin
            step();
            sb_q.push_back(e);
            if (!hold) cfg_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("busy_timeout", 1, 0);
        repeat (3) step();
    endtask

    initial begin
        int xc;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_mode = 2'b00;
        cfg_ds = 4'd0;
        cfg_sr = 1'b0;
        cfg_co = 1'b0;
        data = 1'b0;
        vbias_ok = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("rst_oe", int'(pad_oe), 0);
        chk("rst_ds", int'(pad_ds), 0);
        chk("rst_odp_odn", int'({pad_odp, pad_odn, pad_sr, pad_co}), 0);
        chk("rst_busy_err", int'({busy, err}), 0);
        chk("rst_ready", int'(cfg_ready), 1);

        // Push-pull, no bias needed
        send(2'b01, 4'b0000, 1'b0, 1'b1, -1, 1'b0);
        wait_idle();

        // Data follows with one cycle latency; config pins untouched
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 data = (i == 1);
            step();
            chk("do_follow", int'(pad_do), (i == 1) ? 1 : 0);
            chk("oe_stable", int'(pad_oe), 1);
            chk("ds_stable", int'(pad_ds), 0);
        end

        // Bias arrives late
        vbias_ok = 1'b0;
        repeat (3) step();
        send(2'b01, 4'b0011, 1'b1, 1'b0, 12, 1'b0);
        repeat (12) step();
        vbias_ok = 1'b1;
        wait_idle();

        // Bias never arrives: fallback
        vbias_ok = 1'b0;
        repeat (3) step();
        send(2'b01, 4'b0001, 1'b0, 1'b0, NEVER, 1'b0);
        wait_idle();
        vbias_ok = 1'b1;
        repeat (3) step();

        send(2'b10, 4'b1000, 1'b1, 1'b1, -1, 1'b0);
        wait_idle();
        send(2'b11, 4'b0100, 1'b0, 1'b1, -1, 1'b0);
        wait_idle();

        // Mode off with cfg_valid held through the whole sequence
        xc = xfer_cnt;
        send(2'b00, 4'b0110, 1'b1, 1'b0, -1, 1'b1);
        for (int n = 0; n < 300 && busy; n++) step();
        cfg_valid = 1'b0;
        chk("single_xfer_while_busy", xfer_cnt - xc, 1);
        repeat (3) step();

        // Bias loss while active
        send(2'b01, 4'b0010, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        vbias_ok = 1'b0;
        step();
        step();
        chk("oe_before_loss", int'(pad_oe), 1);
        step();
        chk("oe_after_loss", int'(pad_oe), 0);
        chk("err_after_loss", int'(err), 1);
        vbias_ok = 1'b1;
        repeat (6) step();
        chk("oe_stays_low", int'(pad_oe), 0);

        // Randomised reconfigurations with bias present
        for (int k = 0; k < 8; k++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
            wait_idle();
            repeat ($urandom_range(0, 3)) step();
        end

        // Reset in the middle of SETTLE
        send(2'b01, 4'b1111, 1'b1, 1'b1, -1, 1'b0);
        repeat (S + 4) step();
        chk("busy_in_settle", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pins", int'({pad_do, pad_ds, pad_sr, pad_co, pad_oe, pad_odp, pad_odn}), 0);
        chk("arst_status", int'({busy, err, cfg_ready}), 1);
        sb_q.delete();
        repeat (2) step();
        #2 rst_n = 1'b1;
        repeat (4) step();
        chk("no_partial_cfg_oe", int'(pad_oe), 0);
        chk("no_partial_cfg_ds", int'(pad_ds), 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
